// File: rtl/aes_job_sched.sv
// Two-requester round-robin scheduler for one shared masked AES core.
// Define AES_SCHED_TIMEOUT_EN to abort BUSY jobs after TIMEOUT_CYCLES with rsp_err=1.
module aes_job_sched #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [127:0] req0_key,
   input  logic [127:0] req1_key,
   input  logic [127:0] req0_text,
   input  logic [127:0] req1_text,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   input  logic         rsp0_ready,
   input  logic         rsp1_ready,
   output logic [127:0] rsp_text,
   output logic         rsp_err,
   output logic         aes_ld,
   output logic [127:0] aes_key,
   output logic [127:0] aes_text_in,
   input  logic         aes_done,
   input  logic [127:0] aes_text_out,
   input  logic [2:0]   prng_in,
   output logic         m_in0,
   output logic         m_in1,
   output logic         m_out
);

   typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

   if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_check
      $error("aes_job_sched: CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t       state_q, state_d;
   logic         rr_q, rr_d;
   logic         owner_q, owner_d;
   logic         done_q;
   logic [127:0] key_q, key_d;
   logic [127:0] text_q, text_d;
   logic [127:0] rtext_q, rtext_d;
   logic [2:0]   mask_q, mask_d;
   logic         grant1, accept, done_rise, rsp_take, timeout;

   assign grant1     = req1_valid && (!req0_valid || rr_q);
   assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = (state_q == IDLE) && req0_valid && !grant1;
   assign req1_ready = (state_q == IDLE) && grant1;
   assign done_rise  = aes_done && !done_q;
   assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

   assign aes_ld      = (state_q == LOAD);
   assign rsp0_valid  = (state_q == RESP) && !owner_q;
   assign rsp1_valid  = (state_q == RESP) && owner_q;
   assign rsp_text    = rtext_q;
   assign aes_key     = key_q;
   assign aes_text_in = text_q;
   assign m_in0       = mask_q[0];
   assign m_in1       = mask_q[1];
   assign m_out       = mask_q[2];

`ifdef AES_SCHED_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Counter value k-1 during the k-th BUSY cycle, so the limit hits on cycle TIMEOUT_CYCLES.
   assign timeout = (state_q == BUSY) && (cnt_q == CNT_LIM);
   assign rsp_err = err_q;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == LOAD) begin
         cnt_d = '0;
      end else if (state_q == BUSY) begin
         if (done_rise) begin
            err_d = 1'b0;
         end else if (timeout) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      key_d   = key_q;
      text_d  = text_q;
      mask_d  = mask_q;
      rtext_d = rtext_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = grant1;
               key_d   = grant1 ? req1_key : req0_key;
               text_d  = grant1 ? req1_text : req0_text;
               mask_d  = prng_in;
               state_d = LOAD;
            end
         end
         LOAD: state_d = BUSY;
         BUSY: begin
            // A completion edge on the limit cycle wins over the timeout.
            if (done_rise) begin
               rtext_d = aes_text_out;
               state_d = RESP;
            end else if (timeout) begin
               rtext_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_take) begin
               rr_d    = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
         done_q  <= 1'b0;
         key_q   <= '0;
         text_q  <= '0;
         mask_q  <= '0;
         rtext_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         done_q  <= aes_done;
         key_q   <= key_d;
         text_q  <= text_d;
         mask_q  <= mask_d;
         rtext_q <= rtext_d;
      end
   end

endmodule

// File: doc/aes_job_sched.md
# aes_job_sched

Job scheduler that shares one masked `aes_cipher_top` encryption core between two requesters. It arbitrates round-robin and latches the winner's key and plaintext. It draws fresh mask bits from the xorshift PRNG for each job, pulses `ld`, waits for `done`, and returns the ciphertext on the winner's response channel. It sits between the system-side requesters and the AES core/PRNG pair, in the core's clock domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: BUSY cycles allowed before a job is aborted (used only with timeout compiled in).
- `CNT_W`, default 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  single clock for the block; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  requester has a job pending.
- `req0_ready`, `req1_ready`  out  1  job accepted this cycle.
- `req0_key`, `req1_key`  in  128  AES key.
- `req0_text`, `req1_text`  in  128  plaintext.
- `rsp0_valid`, `rsp1_valid`  out  1  result available.
- `rsp0_ready`, `rsp1_ready`  in  1  requester takes the result.
- `rsp_text`  out  128  ciphertext, shared by both response channels.
- `rsp_err`  out  1  job aborted by timeout.
- `aes_ld`  out  1  load strobe to the core.
- `aes_key`, `aes_text_in`  out  128  operands to the core.
- `aes_done`  in  1  core completion, a level.
- `aes_text_out`  in  128  core ciphertext.
- `prng_in`  in  3  PRNG bits [2:0].
- `m_in0`, `m_in1`, `m_out`  out  1  mask bits to the core.

## Operation
FSM states: IDLE, LOAD, BUSY, RESP.
- **IDLE**
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester selected by priority pointer `rr`.
  - `reqN_ready` = (state==IDLE) && grant==N. Ready is combinational and never asserted for both requesters at once.
- **Accept** (valid && ready):
  - Capture key and text into `aes_key`/`aes_text_in`.
  - Capture `prng_in[0]`, `prng_in[1]`, `prng_in[2]` into `m_in0`, `m_in1`, `m_out`.
  - Record owner. Go to LOAD.
- **LOAD**: `aes_ld`=1 for exactly this one cycle. Clear the counter. Go to BUSY.
- **BUSY**
  - Internal `done_q` registers `aes_done`.
  - Completion is the rising edge (`aes_done` && !`done_q`). On that cycle capture `aes_text_out` into `rsp_text`, clear `rsp_err`, and go to RESP.
  - A `done` level already high when BUSY is entered is ignored until it falls and rises again.
- **RESP**
  - `rspN_valid`=1 for the owner only. Hold `rsp_text`/`rsp_err` stable until `rspN_ready`.
  - On the handshake: `rr` points to the other requester, then go to IDLE.
- **Masks**: `aes_key`, `aes_text_in` and the mask outputs stay constant from accept through the end of RESP. New values are loaded only on the next accept.
- **Reset** (asserted at any time, including mid-job):
  - State goes to IDLE, `rr`=0.
  - All outputs 0: `aes_ld`, `rsp*_valid`, `rsp_err`, `rsp_text`, `aes_key`, `aes_text_in`, `m_*`.
  - Any in-flight job is dropped with no response.

## Timing
- Accept at cycle T; `aes_ld` high at T+1; BUSY from T+2.
- A `done` rising edge sampled at cycle D gives `rsp_valid` at D+1.
- Minimum accept-to-accept spacing is 4 cycles plus the core latency.
- Response and new requests never overlap, so only one job is ever outstanding.
- A response handshake at cycle R makes IDLE at R+1. A request can be accepted at R+1.
- `reqN_ready` is low in every state other than IDLE.
- The block never deasserts `rspN_valid` before `rspN_ready`.

## Configuration
- `AES_SCHED_TIMEOUT_EN` defined:
  - BUSY increments a CNT_W counter every cycle.
  - Reaching `TIMEOUT_CYCLES` without `done` forces RESP with `rsp_err`=1 and `rsp_text`=0.
  - A `done` edge on the same cycle as the limit takes precedence: normal result, `rsp_err`=0.
- `AES_SCHED_TIMEOUT_EN` undefined:
  - No counter. BUSY waits indefinitely. `rsp_err` is tied 0.

## Test plan
- Single job, requester 0: key `cafebabedeadbeefdeadbeef00000000`, text `DBE17F0684546C5571D034433D9A94B7`, core model asserts `done` after 20 cycles.
  - One-cycle `aes_ld` at T+1.
  - `rsp0_valid` with `rsp_text` equal to the golden-model ciphertext, `rsp_err`=0.
  - `rsp1_valid` never asserted.
- Contention: both requesters valid continuously for 4 jobs. Grants alternate 0,1,0,1 and each response goes only to its owner.
- Backpressure: hold `rsp1_ready`=0 for 10 cycles.
  - `rsp1_valid`, `rsp_text` and `m_*` stay stable.
  - `req0_ready` stays 0 until the handshake.
- Mask capture: `prng_in`=3'b101 at accept and toggled every cycle afterwards. `m_in0`=1, `m_in1`=0, `m_out`=1 throughout the job.
- Timeout (`AES_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64): `aes_done` held 0. RESP entered after 64 BUSY cycles with `rsp_err`=1 and `rsp_text`=0. The next job completes normally.
- Reset mid-BUSY: drop `rst_n` for 3 cycles.
  - All outputs 0 immediately (asynchronous).
  - No response is issued for the dropped job.
  - A new request is accepted on the first cycle after release.
